// File: rtl/ppu_framebuffer_if.sv
// Pixel write port of the PPU band framebuffer.
// The PPU core drives the master side; the framebuffer is the slave.
interface ppu_framebuffer_if #(
   parameter int COLOR_WIDTH = 16
);
   logic                   w_valid;
   logic                   w_ready;
   logic [15:0]            w_x;
   logic [15:0]            w_y;
   logic [COLOR_WIDTH-1:0] w_color;
   logic                   w_commit;

   modport master (
      output w_valid,
      output w_x,
      output w_y,
      output w_color,
      output w_commit,
      input  w_ready
   );

   modport slave (
      input  w_valid,
      input  w_x,
      input  w_y,
      input  w_color,
      input  w_commit,
      output w_ready
   );
endinterface

// File: rtl/ppu_framebuffer.sv
// Double-buffered band framebuffer: the core draws into the back bank while
// scanout reads the front bank; banks swap at the end of this band's scan.
module ppu_framebuffer #(
   parameter int BAND_WIDTH    = 800,
   parameter int BAND_HEIGHT   = 60,
   parameter int COLOR_WIDTH   = 16,
   parameter int CORES_COUNT   = 10,
   parameter int CORE_ID       = 0,
   parameter int BUFFER_ADDR_W = 32,
   parameter int CLEAR_EN      = 1,
   parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0,
   localparam int SEL_W = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   ppu_framebuffer_if.slave         wr,
   input  logic [BUFFER_ADDR_W-1:0] raddress,
   input  logic [SEL_W-1:0]         rselect,
   output logic [COLOR_WIDTH-1:0]   rdata,
   output logic                     swapped,
   output logic                     front_bank
);

   localparam int SIZE  = BAND_WIDTH * BAND_HEIGHT;
   localparam int AW    = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int DEPTH = 2 ** (AW + 1);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_DRAW,
      S_PENDING
   } state_e;

   state_e                 state_q, state_d;
   logic [AW-1:0]          clr_addr_q, clr_addr_d;
   logic                   front_q, front_d;
   logic                   swapped_q, swapped_d;
   logic                   seen_q, seen_d;
   logic                   at_last, at_last_q;
   logic                   scan_end;

   logic                   p1_valid_q, p1_valid_d;
   logic [AW-1:0]          p1_addr_q, p1_addr_d;
   logic [COLOR_WIDTH-1:0] p1_color_q, p1_color_d;

   logic [31:0]            wr_lin;
   logic                   in_range;
   logic                   accept;

   logic                   mem_we;
   logic [AW:0]            mem_waddr;
   logic [COLOR_WIDTH-1:0] mem_wdata;
   logic [AW:0]            mem_raddr;
   logic [COLOR_WIDTH-1:0] rdata_q;

   logic [COLOR_WIDTH-1:0] mem [0:DEPTH-1];

   assign wr.w_ready = (state_q == S_DRAW);
   assign accept     = wr.w_valid && wr.w_ready;

   // Full 32-bit linear address so out-of-range coordinates never alias.
   always_comb begin
      wr_lin   = 32'(wr.w_y) * 32'(BAND_WIDTH) + 32'(wr.w_x);
      in_range = (32'(wr.w_x) < 32'(BAND_WIDTH))
              && (32'(wr.w_y) < 32'(BAND_HEIGHT))
              && (wr_lin < 32'(SIZE));
   end

   assign at_last  = (rselect == SEL_W'(CORE_ID))
                  && (raddress == BUFFER_ADDR_W'(SIZE - 1));
   assign scan_end = at_last_q && !at_last;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      front_d    = front_q;
      swapped_d  = 1'b0;
      seen_d     = seen_q;
      p1_valid_d = accept && in_range;
      p1_addr_d  = AW'(wr_lin);
      p1_color_d = wr.w_color;
      mem_we     = p1_valid_q;
      mem_waddr  = {~front_q, p1_addr_q};
      mem_wdata  = p1_color_q;
      unique case (state_q)
         S_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = {~front_q, clr_addr_q};
            mem_wdata = CLEAR_COLOR;
            if (clr_addr_q == AW'(SIZE - 1)) begin
               clr_addr_d = '0;
               state_d    = S_DRAW;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
            end
         end
         S_DRAW: begin
            if (wr.w_commit) begin
               state_d = S_PENDING;
               seen_d  = 1'b0;
            end
         end
         S_PENDING: begin
            // A scan end seen while a pixel is in flight is held until it lands.
            if (scan_end || seen_q) begin
               if (p1_valid_q) begin
                  seen_d = 1'b1;
               end else begin
                  front_d   = ~front_q;
                  swapped_d = 1'b1;
                  seen_d    = 1'b0;
                  state_d   = (CLEAR_EN != 0) ? S_CLEAR : S_DRAW;
               end
            end
         end
         default: state_d = S_CLEAR;
      endcase
   end

   // Reads sampled on the swap edge already see the new front bank.
   assign mem_raddr = {front_d, AW'(raddress)};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_CLEAR;
         clr_addr_q <= '0;
         front_q    <= 1'b0;
         swapped_q  <= 1'b0;
         seen_q     <= 1'b0;
         at_last_q  <= 1'b0;
         p1_valid_q <= 1'b0;
         p1_addr_q  <= '0;
         p1_color_q <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         front_q    <= front_d;
         swapped_q  <= swapped_d;
         seen_q     <= seen_d;
         at_last_q  <= at_last;
         p1_valid_q <= p1_valid_d;
         p1_addr_q  <= p1_addr_d;
         p1_color_q <= p1_color_d;
         rdata_q    <= mem[mem_raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign rdata      = rdata_q;
   assign swapped    = swapped_q;
   assign front_bank = front_q;

endmodule

// File: tb/tb_ppu_framebuffer.sv
// Bench for ppu_framebuffer on a small band, checked against a
// two-bank array model of the frame contents.
module tb_ppu_framebuffer;

   localparam int BW    = 20;
   localparam int BH    = 6;
   localparam int SIZE  = BW * BH;
   localparam int CORES = 4;
   localparam int CID   = 2;
   localparam int CW    = 16;
   localparam logic [CW-1:0] CC = 16'h5A5A;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   raddress;
   logic [1:0]    rselect;
   logic [CW-1:0] rdata;
   logic          swapped;
   logic          front_bank;

   ppu_framebuffer_if #(.COLOR_WIDTH(CW)) wif ();

   ppu_framebuffer #(
      .BAND_WIDTH(BW),
      .BAND_HEIGHT(BH),
      .COLOR_WIDTH(CW),
      .CORES_COUNT(CORES),
      .CORE_ID(CID),
      .BUFFER_ADDR_W(32),
      .CLEAR_EN(1),
      .CLEAR_COLOR(CC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wr(wif),
      .raddress(raddress),
      .rselect(rselect),
      .rdata(rdata),
      .swapped(swapped),
      .front_bank(front_bank)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [CW-1:0] mem_m   [2][SIZE];
   bit            known_m [2][SIZE];
   bit            front_m;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear(input bit b);
      for (int a = 0; a < SIZE; a++) begin
         mem_m[b][a]   = CC;
         known_m[b][a] = 1'b1;
      end
   endtask

   task automatic model_reset;
      front_m = 1'b0;
      for (int a = 0; a < SIZE; a++) known_m[0][a] = 1'b0;
      model_clear(1'b1);
   endtask

   task automatic model_write(input int x, input int y, input logic [CW-1:0] c);
      if (x < BW && y < BH) begin
         mem_m[!front_m][y * BW + x]   = c;
         known_m[!front_m][y * BW + x] = 1'b1;
      end
   endtask

   task automatic model_swap;
      front_m = !front_m;
      model_clear(!front_m);
   endtask

   task automatic drive_write(input int x, input int y,
                              input logic [CW-1:0] c, input bit cm);
      wif.w_valid  = 1'b1;
      wif.w_x      = 16'(x);
      wif.w_y      = 16'(y);
      wif.w_color  = c;
      wif.w_commit = cm;
      tick();
      wif.w_valid  = 1'b0;
      wif.w_commit = 1'b0;
      model_write(x, y, c);
   endtask

   task automatic commit_pulse;
      wif.w_commit = 1'b1;
      tick();
      wif.w_commit = 1'b0;
   endtask

   task automatic sweep_scan(output int ns);
      ns = 0;
      rselect = 2'(CID);
      for (int a = 0; a < SIZE; a++) begin
         raddress = 32'(a);
         tick();
         ns += int'(swapped);
      end
      rselect  = 2'd0;
      raddress = 32'd0;
      repeat (4) begin
         tick();
         ns += int'(swapped);
      end
   endtask

   task automatic wait_draw(output int n);
      n = 0;
      while (!wif.w_ready && n < 4 * SIZE) begin
         tick();
         n++;
      end
   endtask

   task automatic rd(input int a, output logic [CW-1:0] d);
      rselect  = 2'd0;
      raddress = 32'(a);
      tick();
      d = rdata;
   endtask

   task automatic test_reset;
      int n, sw;
      rst = 1'b1;
      wif.w_valid = 1'b0; wif.w_commit = 1'b0;
      wif.w_x = '0; wif.w_y = '0; wif.w_color = '0;
      rselect = 2'd0; raddress = 32'd0;
      tick(); tick();
      checks++;
      if (front_bank !== 1'b0) begin
         errors++; $display("FAIL reset_front: got %b want 0", front_bank);
      end
      checks++;
      if (wif.w_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b want 0", wif.w_ready);
      end
      checks++;
      if (swapped !== 1'b0) begin
         errors++; $display("FAIL reset_swapped: got %b want 0", swapped);
      end
      checks++;
      if (rdata !== '0) begin
         errors++; $display("FAIL reset_rdata: got %h want 0", rdata);
      end
      rst = 1'b0;
      model_reset();
      n = 0; sw = 0;
      while (!wif.w_ready && n < 4 * SIZE) begin
         tick();
         n++;
         sw += int'(swapped);
      end
      checks++;
      if (n != SIZE) begin
         errors++; $display("FAIL clear_len: got %0d want %0d", n, SIZE);
      end
      checks++;
      if (sw != 0) begin
         errors++; $display("FAIL clear_swaps: got %0d want 0", sw);
      end
   endtask

   task automatic test_clear_bank;
      int ns, n;
      logic [CW-1:0] d;
      commit_pulse();
      checks++;
      if (wif.w_ready !== 1'b0) begin
         errors++; $display("FAIL pend_ready: got %b want 0", wif.w_ready);
      end
      sweep_scan(ns);
      model_swap();
      checks++;
      if (ns != 1) begin
         errors++; $display("FAIL clr_swaps: got %0d want 1", ns);
      end
      checks++;
      if (front_bank !== front_m) begin
         errors++; $display("FAIL clr_front: got %b want %b", front_bank, front_m);
      end
      wait_draw(n);
      checks++;
      if (!wif.w_ready) begin
         errors++; $display("FAIL clr_draw_timeout: got %0d cycles", n);
      end
      for (int a = 0; a < SIZE; a++) begin
         rd(a, d);
         checks++;
         if (d !== CC) begin
            errors++; $display("FAIL clr_bank a=%0d: got %h want %h", a, d, CC);
         end
      end
   endtask

   task automatic test_draw_swap;
      int ns, n;
      logic [CW-1:0] d;
      repeat (12) drive_write($urandom_range(BW - 1), $urandom_range(BH - 1),
                              CW'($urandom), 1'b0);
      drive_write(5, 2, 16'hABCD, 1'b0);
      commit_pulse();
      sweep_scan(ns);
      model_swap();
      checks++;
      if (ns != 1) begin
         errors++; $display("FAIL draw_swaps: got %0d want 1", ns);
      end
      checks++;
      if (front_bank !== front_m) begin
         errors++; $display("FAIL draw_front: got %b want %b", front_bank, front_m);
      end
      wait_draw(n);
      rd(2 * BW + 5, d);
      checks++;
      if (d !== 16'hABCD) begin
         errors++; $display("FAIL draw_pixel: got %h want abcd", d);
      end
      for (int a = 0; a < SIZE; a++) begin
         rd(a, d);
         checks++;
         if (known_m[front_m][a] && d !== mem_m[front_m][a]) begin
            errors++;
            $display("FAIL draw_bank a=%0d: got %h want %h", a, d, mem_m[front_m][a]);
         end
      end
   endtask

   task automatic test_out_of_range;
      int ns, n;
      int addrs [5];
      logic [CW-1:0] d;
      logic [CW-1:0] pix;
      pix = CW'($urandom_range(16'hFFFE)) ^ 16'h0001;
      drive_write(BW, 0, CW'($urandom), 1'b0);
      drive_write(0, BH, CW'($urandom), 1'b0);
      drive_write(BW + 5, 1, CW'($urandom), 1'b0);
      drive_write(65535, 65535, CW'($urandom), 1'b0);
      drive_write(3, 3, pix, 1'b0);
      commit_pulse();
      sweep_scan(ns);
      model_swap();
      checks++;
      if (ns != 1) begin
         errors++; $display("FAIL oor_swaps: got %0d want 1", ns);
      end
      wait_draw(n);
      addrs = '{0, SIZE - 1, BW, 2 * BW + 5, 3 * BW + 3};
      foreach (addrs[i]) begin
         rd(addrs[i], d);
         checks++;
         if (d !== mem_m[front_m][addrs[i]]) begin
            errors++;
            $display("FAIL oor a=%0d: got %h want %h", addrs[i], d, mem_m[front_m][addrs[i]]);
         end
      end
   endtask

   task automatic test_stall;
      int ns, n;
      rselect  = 2'd0;
      raddress = 32'd0;
      commit_pulse();
      rselect  = 2'(CID);
      raddress = 32'(SIZE - 1);
      ns = 0;
      repeat (20) begin
         tick();
         ns += int'(swapped);
      end
      checks++;
      if (ns != 0) begin
         errors++; $display("FAIL stall_early: got %0d swaps want 0", ns);
      end
      checks++;
      if (front_bank !== front_m) begin
         errors++; $display("FAIL stall_front: got %b want %b", front_bank, front_m);
      end
      raddress = 32'd0;
      repeat (4) begin
         tick();
         ns += int'(swapped);
      end
      model_swap();
      checks++;
      if (ns != 1) begin
         errors++; $display("FAIL stall_swaps: got %0d want 1", ns);
      end
      checks++;
      if (front_bank !== front_m) begin
         errors++; $display("FAIL stall_front2: got %b want %b", front_bank, front_m);
      end
      rselect = 2'd0;
      wait_draw(n);
   endtask

   task automatic test_commit_same_cycle;
      int ns, n;
      logic [CW-1:0] d;
      drive_write(0, 0, 16'h1234, 1'b1);
      checks++;
      if (wif.w_ready !== 1'b0) begin
         errors++; $display("FAIL same_ready: got %b want 0", wif.w_ready);
      end
      commit_pulse();
      sweep_scan(ns);
      model_swap();
      checks++;
      if (ns != 1) begin
         errors++; $display("FAIL same_swaps: got %0d want 1", ns);
      end
      wait_draw(n);
      rd(0, d);
      checks++;
      if (d !== 16'h1234) begin
         errors++; $display("FAIL same_pixel: got %h want 1234", d);
      end
      sweep_scan(ns);
      checks++;
      if (ns != 0) begin
         errors++; $display("FAIL second_commit: got %0d swaps want 0", ns);
      end
   endtask

   task automatic test_back_to_back;
      int ns, n, x, y;
      bit cm;
      logic [CW-1:0] d;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 30; i++) begin
            x  = $urandom_range(BW + 3);
            y  = $urandom_range(BH + 1);
            cm = (r % 2 == 1) && (i == 29);
            wif.w_valid  = 1'b1;
            wif.w_x      = 16'(x);
            wif.w_y      = 16'(y);
            wif.w_color  = CW'($urandom);
            wif.w_commit = cm;
            tick();
            model_write(x, y, wif.w_color);
         end
         wif.w_valid  = 1'b0;
         wif.w_commit = 1'b0;
         if (r % 2 == 0) commit_pulse();
         sweep_scan(ns);
         model_swap();
         checks++;
         if (ns != 1) begin
            errors++; $display("FAIL b2b_swaps r=%0d: got %0d want 1", r, ns);
         end
         wait_draw(n);
         for (int a = 0; a < SIZE; a++) begin
            rd(a, d);
            checks++;
            if (known_m[front_m][a] && d !== mem_m[front_m][a]) begin
               errors++;
               $display("FAIL b2b r=%0d a=%0d: got %h want %h", r, a, d, mem_m[front_m][a]);
            end
         end
      end
   endtask

   task automatic test_reset_pending;
      int ns, n, sw;
      logic [CW-1:0] d;
      if (!front_m) begin
         commit_pulse();
         sweep_scan(ns);
         model_swap();
         wait_draw(n);
      end
      drive_write(1, 1, 16'hBEEF, 1'b0);
      commit_pulse();
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (front_bank !== 1'b0) begin
         errors++; $display("FAIL rstp_front: got %b want 0", front_bank);
      end
      checks++;
      if (wif.w_ready !== 1'b0) begin
         errors++; $display("FAIL rstp_ready: got %b want 0", wif.w_ready);
      end
      checks++;
      if (swapped !== 1'b0) begin
         errors++; $display("FAIL rstp_swapped: got %b want 0", swapped);
      end
      model_reset();
      n = 0; sw = 0;
      while (!wif.w_ready && n < 4 * SIZE) begin
         rselect  = 2'(CID);
         raddress = 32'(n % SIZE);
         tick();
         n++;
         sw += int'(swapped);
      end
      rselect = 2'd0;
      repeat (3) begin
         tick();
         sw += int'(swapped);
      end
      checks++;
      if (n != SIZE) begin
         errors++; $display("FAIL rstp_clear_len: got %0d want %0d", n, SIZE);
      end
      checks++;
      if (sw != 0) begin
         errors++; $display("FAIL rstp_swaps: got %0d want 0", sw);
      end
      commit_pulse();
      sweep_scan(ns);
      model_swap();
      wait_draw(n);
      for (int a = 0; a < SIZE; a++) begin
         rd(a, d);
         checks++;
         if (d !== mem_m[front_m][a]) begin
            errors++;
            $display("FAIL rstp_bank a=%0d: got %h want %h", a, d, mem_m[front_m][a]);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_clear_bank();
      test_draw_swap();
      test_out_of_range();
      test_stall();
      test_commit_same_cycle();
      test_back_to_back();
      test_reset_pending();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ppu_framebuffer.md
# ppu_framebuffer

Per-core double-buffered band framebuffer sitting directly upstream of the VGA scanout master. Each PPU core draws into the back bank through a pixel write port, while the scanout master reads the front bank through `raddress`/`rselect`/`rdata`. On a core's frame commit, banks swap at the next end of this band's scanout, and the new back bank is optionally cleared. One instance per core; instances share `raddress`/`rselect`, and their `rdata` outputs are muxed by `rselect` outside this block.

## Interface
- `BAND_WIDTH`, 800: pixels per line (equals VGA width).
- `BAND_HEIGHT`, 60: lines per band (VGA height / cores count).
- `COLOR_WIDTH`, 16: pixel width.
- `CORES_COUNT`, 10: number of PPU cores; sets `rselect` width.
- `CORE_ID`, 0: `rselect` value addressing this instance.
- `BUFFER_ADDR_W`, 32: `raddress` width.
- `CLEAR_EN`, 1: clear the back bank after each swap.
- `CLEAR_COLOR`, 0: clear value.
- `clk` in 1: the single clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `w_valid` in 1: pixel write request.
- `w_ready` out 1: write accepted when `w_valid && w_ready`.
- `w_x` in 16: column.
- `w_y` in 16: line within the band.
- `w_color` in COLOR_WIDTH: pixel value.
- `w_commit` in 1: single-cycle pulse marking that the back bank is complete.
- `raddress` in BUFFER_ADDR_W: scanout read address, 0..SIZE-1.
- `rselect` in $clog2(CORES_COUNT): band currently scanned.
- `rdata` out COLOR_WIDTH: front-bank pixel at `raddress`.
- `swapped` out 1: single-cycle pulse on bank swap.
- `front_bank` out 1: index of the bank being scanned out.

## Operation
- SIZE = BAND_WIDTH*BAND_HEIGHT. Storage is 2*SIZE words, addressed as `{bank, addr}`. The back bank is `!front_bank`.
- Write address = `w_y*BAND_WIDTH + w_x`. Width-extend before the multiply; no truncation is allowed before the compare against SIZE.
- If `w_x >= BAND_WIDTH` or `w_y >= BAND_HEIGHT`, the write is accepted but dropped and memory is unchanged.
- Read: `rdata` ≤ mem[{front_bank, raddress}] every cycle, regardless of `rselect`.
- Scan-end detection:
  - `at_last` = (`rselect == CORE_ID`) && (`raddress == SIZE-1`).
  - `scan_end` = registered `at_last` && !`at_last`, i.e. the falling edge.
  - A stalled scanout that holds the last address yields exactly one `scan_end`.
  - Works for CORES_COUNT = 1, where the address wraps to 0.
- State machine, with states CLEAR, DRAW and PENDING:
  - CLEAR:
    - Writes CLEAR_COLOR to the back bank at `clr_addr` = 0..SIZE-1, one word per cycle; `w_ready` = 0.
    - After writing SIZE-1, go to DRAW.
  - DRAW:
    - `w_ready` = 1.
    - On `w_commit`, go to PENDING. A write accepted in the same cycle lands in the back bank before the swap.
  - PENDING:
    - `w_ready` = 0.
    - On `scan_end`: toggle `front_bank`, pulse `swapped`, then go to CLEAR if CLEAR_EN, else DRAW.
  - `w_commit` is ignored outside DRAW.
  - `scan_end` outside PENDING has no effect.
- Reset values:
  - State = CLEAR with `clr_addr` = 0, so bank 1 is cleared.
  - `front_bank` = 0, `rdata` = 0, `w_ready` = 0, `swapped` = 0.
  - Bank 0 contents are undefined after reset.
- `rst` asserted mid-CLEAR or mid-PENDING aborts the operation. Any pending commit is lost.

## Timing
- Read latency: 1 cycle, with `rdata` registered. `raddress` at edge N gives `rdata` valid after edge N+1.
- Write latency:
  - Address computation is registered in one stage; the memory write follows 1 cycle later (2 cycles from acceptance to storage).
  - The write pipeline drains even if state leaves DRAW.
  - The swap must wait until the pipeline is empty, so the last accepted pixel is in the old back bank.
- `swapped` and the `front_bank` toggle occur on the edge after the cycle `scan_end` is high.
- The first read of the new front bank is at the first `raddress` after the swap edge. Reads landing on the swap edge use the new bank.
- CLEAR lasts exactly SIZE cycles. Minimum commit-to-next-DRAW time = remaining scan time + 1 + SIZE (CLEAR_EN = 1).
- Memory must map to one simple-dual-port RAM: one write port shared by the pixel pipe and the clear counter, and one read port.

## Test plan
- Reset, then hold `w_valid` = 0: `w_ready` stays 0 for SIZE cycles, then rises. Scanning bank 1 after a forced swap reads all CLEAR_COLOR.
- In DRAW:
  - Write (x=5, y=2, 0xABCD).
  - Commit.
  - Drive `rselect` = CORE_ID and sweep `raddress` 0..SIZE-1, then change `rselect`.
  - Expect: one `swapped` pulse, `front_bank` 0→1, and a subsequent read of address 1605 returns 0xABCD one cycle later.
- Write (x=800, y=0) and (x=0, y=60), then commit and swap: both addresses 0 and SIZE-1 read CLEAR_COLOR.
- Hold `raddress` = SIZE-1 with `rselect` = CORE_ID for 20 cycles during PENDING: no swap until the address changes, then exactly one `swapped`.
- `w_commit` in the same cycle as a write of (0, 0, 0x1234): that pixel appears in the new front bank after the swap. A second `w_commit` during PENDING is ignored, giving exactly one swap.
- Assert `rst` mid-PENDING: `front_bank` = 0, `w_ready` = 0, no `swapped` pulse, and CLEAR restarts from address 0.
